// File: rtl/avg_capture_ctrl_pkg.sv
// Shared definitions for the averager capture sequencer: FSM state encodings
// and the width helper for the decimation exponent k.
package avg_capture_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Bits needed to hold any k in 0..bit_diff.
    function automatic int k_width(input int bit_diff);
        return $clog2(bit_diff) + 1;
    endfunction

endpackage

// File: rtl/avg_capture_ctrl_addr_counter.sv
// Capture buffer address counter: cleared and loaded with the sample count at
// arm time, advances on each write, flags the write that completes the capture.
module capture_addr_counter #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] nsamp,
    input  logic         en,
    output logic [W-1:0] addr,
    output logic         last
);

    logic [W-1:0] nsamp_l;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr    <= '0;
            nsamp_l <= '0;
        end else if (load) begin
            addr    <= '0;
            nsamp_l <= nsamp;
        end else if (en) begin
            addr <= addr + W'(1);
        end
    end

    // nsamp_l of 0 wraps to all-ones here, which yields a full 2^W capture.
    assign last = (addr == nsamp_l - W'(1));

endmodule

// File: rtl/avg_capture_ctrl.sv
// Sequencer for the moving-average/decimation datapath: arms the averager, gates
// ADC strobes, writes decimated outputs to the capture buffer.
// Optional watchdog: define AVG_CTRL_TIMEOUT_EN to add the TIMEOUT_CYC counter.
module avg_capture_ctrl
    import avg_capture_ctrl_pkg::*;
#(
    parameter int BITS_ADC   = 8,
    parameter int BITS_ACUM  = 12,
    parameter int BITS_NSAMP = 10,
`ifdef AVG_CTRL_TIMEOUT_EN
    parameter int TIMEOUT_CYC = 65535,
`endif
    localparam int BIT_DIFF = BITS_ACUM - BITS_ADC,
    localparam int K_W      = k_width(BIT_DIFF)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [K_W-1:0]        cfg_k,
    input  logic                  cfg_k_wr,
    input  logic [BITS_NSAMP-1:0] cfg_nsamp,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  adc_rdy,
    input  logic                  avg_rdy_out,
    output logic                  avg_rst,
    output logic [K_W-1:0]        avg_k,
    output logic                  avg_rdy_in,
    output logic                  buf_we,
    output logic [BITS_NSAMP-1:0] buf_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic                  timeout
);

    state_t         state, state_nxt;
    logic [K_W-1:0] pending_k;
    logic [K_W-1:0] k_clamped;
    logic           last_write;
    logic           to_hit;
    logic           set_abort, set_to;

    assign k_clamped = (cfg_k > K_W'(BIT_DIFF)) ? K_W'(BIT_DIFF) : cfg_k;

    assign avg_rst    = (state != ST_RUN);
    assign avg_rdy_in = (state == ST_RUN) && adc_rdy;
    assign buf_we     = (state == ST_RUN) && avg_rdy_out;
    assign busy       = (state == ST_ARM) || (state == ST_RUN);
    assign done       = (state == ST_DONE);

    capture_addr_counter #(.W(BITS_NSAMP)) u_addr (
        .clk   (clk),
        .rst   (rst),
        .load  (state == ST_ARM),
        .nsamp (cfg_nsamp),
        .en    (buf_we),
        .addr  (buf_addr),
        .last  (last_write)
    );

`ifdef AVG_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (!rst)
            to_cnt <= '0;
        else if (state == ST_ARM || avg_rdy_out)
            to_cnt <= '0;
        else if (state == ST_RUN)
            to_cnt <= to_cnt + TO_W'(1);
    end

    // Fires on the TIMEOUT_CYC-th consecutive RUN cycle without an output.
    assign to_hit = (state == ST_RUN) && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    assign to_hit = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        set_abort = 1'b0;
        set_to    = 1'b0;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_ARM;
            ST_ARM:  state_nxt = ST_RUN;
            ST_RUN: begin
                if (buf_we && last_write) begin
                    state_nxt = ST_DONE;
                end else if (stop) begin
                    state_nxt = ST_DONE;
                    set_abort = 1'b1;
                end else if (to_hit) begin
                    state_nxt = ST_DONE;
                    set_abort = 1'b1;
                    set_to    = 1'b1;
                end
            end
            // Held start skips IDLE so continuous captures are DONE+ARM apart.
            ST_DONE: state_nxt = start ? ST_ARM : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            pending_k <= '0;
            avg_k     <= '0;
            aborted   <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cfg_k_wr)
                pending_k <= k_clamped;
            if (state == ST_ARM) begin
                avg_k   <= pending_k;
                aborted <= 1'b0;
                timeout <= 1'b0;
            end else begin
                if (set_abort) aborted <= 1'b1;
                if (set_to)    timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_avg_capture_ctrl.sv
// Directed bench for avg_capture_ctrl (BITS_NSAMP=4); the AVG_CTRL_TIMEOUT_EN
// build additionally exercises the watchdog with TIMEOUT_CYC=20.
module tb_avg_capture_ctrl;

    localparam int K_W = 3;
    localparam int NW  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [K_W-1:0] cfg_k;
    logic          cfg_k_wr;
    logic [NW-1:0] cfg_nsamp;
    logic          start, stop, adc_rdy, avg_rdy_out;
    logic          avg_rst, avg_rdy_in, buf_we, busy, done, aborted, timeout;
    logic [K_W-1:0] avg_k;
    logic [NW-1:0] buf_addr;

    logic          use_model, drv_rdy_out, model_out;
    int            model_cnt;
    int            n_tests = 0;
    int            n_fail  = 0;

    always #5 clk = ~clk;

    avg_capture_ctrl #(
        .BITS_ADC   (8),
        .BITS_ACUM  (12),
`ifdef AVG_CTRL_TIMEOUT_EN
        .TIMEOUT_CYC(20),
`endif
        .BITS_NSAMP (NW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_k      (cfg_k),
        .cfg_k_wr   (cfg_k_wr),
        .cfg_nsamp  (cfg_nsamp),
        .start      (start),
        .stop       (stop),
        .adc_rdy    (adc_rdy),
        .avg_rdy_out(avg_rdy_out),
        .avg_rst    (avg_rst),
        .avg_k      (avg_k),
        .avg_rdy_in (avg_rdy_in),
        .buf_we     (buf_we),
        .buf_addr   (buf_addr),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .timeout    (timeout)
    );

    // Behavioural averager: one output strobe per 2^k accepted input strobes.
    always @(posedge clk) begin
        if (avg_rst) begin
            model_cnt <= 0;
            model_out <= 1'b0;
        end else begin
            model_out <= 1'b0;
            if (avg_rdy_in) begin
                if (model_cnt == (1 << avg_k) - 1) begin
                    model_cnt <= 0;
                    model_out <= 1'b1;
                end else begin
                    model_cnt <= model_cnt + 1;
                end
            end
        end
    end

    assign avg_rdy_out = use_model ? model_out : drv_rdy_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic write_k(input logic [K_W-1:0] k);
        cfg_k = k; cfg_k_wr = 1'b1;
        cyc();
        cfg_k_wr = 1'b0;
    endtask

    // Leaves the DUT in its first RUN cycle.
    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
    endtask

    task automatic write_n(input int n);
        drv_rdy_out = 1'b1;
        repeat (n) cyc();
        drv_rdy_out = 1'b0;
    endtask

    initial begin
        int  widx;
        bit  got_done;
        int  lat;

        rst = 1'b0; cfg_k = '0; cfg_k_wr = 1'b0; cfg_nsamp = '0;
        start = 1'b0; stop = 1'b0; adc_rdy = 1'b0;
        use_model = 1'b0; drv_rdy_out = 1'b0;
        repeat (2) cyc();

        // Reset state; strobes outside RUN are blocked.
        adc_rdy = 1'b1; drv_rdy_out = 1'b1;
        settle();
        check("rst_avg_rst",  avg_rst, 1);
        check("rst_avg_k",    avg_k, 0);
        check("rst_addr",     buf_addr, 0);
        check("rst_busy",     busy, 0);
        check("rst_done",     done, 0);
        check("rst_aborted",  aborted, 0);
        check("rst_timeout",  timeout, 0);
        check("rst_rdy_in",   avg_rdy_in, 0);
        check("rst_we",       buf_we, 0);
        drv_rdy_out = 1'b0;
        rst = 1'b1;
        cyc();

        // 1: k=2, 4 samples with a real averager.
        write_k(3'd2);
        cfg_nsamp = 4'd4; use_model = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        settle();
        check("t1_arm_busy",    busy, 1);
        check("t1_arm_avg_rst", avg_rst, 1);
        check("t1_arm_rdy_in",  avg_rdy_in, 0);
        cyc();
        settle();
        check("t1_avg_k",      avg_k, 2);
        check("t1_run_avg_rst", avg_rst, 0);
        check("t1_run_rdy_in", avg_rdy_in, 1);
        widx = 0; got_done = 1'b0;
        for (int i = 0; i < 80 && !got_done; i++) begin
            if (buf_we) begin
                check("t1_addr", buf_addr, widx);
                widx++;
            end
            if (done) begin
                got_done = 1'b1;
                check("t1_done_addr",    buf_addr, 4);
                check("t1_done_aborted", aborted, 0);
            end else begin
                cyc();
                settle();
            end
        end
        check("t1_writes",    widx, 4);
        check("t1_done_seen", got_done, 1);
        cyc();
        settle();
        check("t1_done_once", done, 0);
        check("t1_idle_busy", busy, 0);
        use_model = 1'b0; adc_rdy = 1'b0;

        // 2: k clamps to 4; a write during RUN waits for the next capture.
        write_k(3'd7);
        cfg_nsamp = 4'd2;
        pulse_start();
        settle();
        check("t2_clamp", avg_k, 4);
        write_k(3'd1);
        settle();
        check("t2_k_held", avg_k, 4);
        write_n(2);
        settle();
        check("t2_done", done, 1);
        check("t2_addr", buf_addr, 2);
        cyc();

        // 3a: stop after the 3rd of 8 writes.
        cfg_nsamp = 4'd8;
        pulse_start();
        settle();
        check("t2_new_k", avg_k, 1);
        write_n(3);
        stop = 1'b1;
        settle();
        check("t3_stop_no_we", buf_we, 0);
        cyc();
        stop = 1'b0;
        settle();
        check("t3_done",    done, 1);
        check("t3_aborted", aborted, 1);
        check("t3_addr",    buf_addr, 3);
        stop = 1'b1;
        cyc();
        settle();
        check("t3_abort_kept",  aborted, 1);
        check("t3_idle_stop",   busy, 0);
        stop = 1'b0;

        // 3b: stop coinciding with the final write is a normal completion.
        pulse_start();
        write_n(7);
        settle();
        check("t3b_addr7", buf_addr, 7);
        drv_rdy_out = 1'b1; stop = 1'b1;
        settle();
        check("t3b_we", buf_we, 1);
        cyc();
        drv_rdy_out = 1'b0; stop = 1'b0;
        settle();
        check("t3b_done",    done, 1);
        check("t3b_aborted", aborted, 0);
        check("t3b_addr",    buf_addr, 8);
        cyc();

        // 4: nsamp=0 means 16 writes and a wrapped address.
        cfg_nsamp = 4'd0;
        pulse_start();
        write_n(15);
        settle();
        check("t4_busy15", busy, 1);
        check("t4_addr15", buf_addr, 15);
        write_n(1);
        settle();
        check("t4_done", done, 1);
        check("t4_wrap", buf_addr, 0);
        cyc();

        // start&stop together in IDLE arms; stop in ARM is ignored.
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0;
        settle();
        check("ss_arm", busy, 1);
        cyc();
        stop = 1'b0;
        settle();
        check("ss_run",     busy, 1);
        check("ss_run_rst", avg_rst, 0);

        // 5a: reset mid-capture drops straight to IDLE with no done pulse.
        rst = 1'b0;
        cyc();
        settle();
        check("t5_busy",    busy, 0);
        check("t5_avg_rst", avg_rst, 1);
        check("t5_done",    done, 0);
        check("t5_addr",    buf_addr, 0);
        rst = 1'b1;
        cyc();
        settle();
        check("t5_no_done", done, 0);

        // 5b: start held high gives back-to-back captures.
        cfg_nsamp = 4'd1; drv_rdy_out = 1'b1; start = 1'b1;
        cyc();
        cyc();
        settle();
        check("t5b_we", buf_we, 1);
        cyc();
        settle();
        check("t5b_done1", done, 1);
        cyc();
        settle();
        check("t5b_rearm",     busy, 1);
        check("t5b_arm_rst",   avg_rst, 1);
        check("t5b_done_pulse", done, 0);
        cyc();
        settle();
        check("t5b_run2", avg_rst, 0);
        check("t5b_addr", buf_addr, 0);
        start = 1'b0;
        cyc();
        settle();
        check("t5b_done2", done, 1);
        drv_rdy_out = 1'b0;
        cyc();
        settle();
        check("t5b_idle", busy, 0);

`ifdef AVG_CTRL_TIMEOUT_EN
        // 6: no averager output after start -> timeout at ARM+21.
        cfg_nsamp = 4'd4;
        start = 1'b1;
        cyc();
        start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            cyc();
            settle();
            if (done) lat = i;
        end
        check("t6_latency", lat, 21);
        check("t6_timeout", timeout, 1);
        check("t6_aborted", aborted, 1);
        cyc();
`else
        // Without the watchdog RUN waits indefinitely for outputs.
        cfg_nsamp = 4'd4;
        pulse_start();
        repeat (25) cyc();
        settle();
        check("t6_still_run", busy, 1);
        check("t6_timeout0",  timeout, 0);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        settle();
        check("t6_stop_done",    done, 1);
        check("t6_stop_aborted", aborted, 1);
        cyc();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
